// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: state encoding, occupancy width
// and field-packing helpers for the per-stage payload/ctrl layouts.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic rf_we;
    logic mem_we;
    logic mem2rf;
  } stage_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } exmem_data_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [31:0] mem_val;
    logic [31:0] waddr;
  } memwb_data_t;

  function automatic logic [95:0] pack_exmem(input logic [31:0] alu_res,
                                             input logic [31:0] wdata,
                                             input logic [31:0] waddr);
    exmem_data_t p;
    p.alu_res = alu_res;
    p.wdata   = wdata;
    p.waddr   = waddr;
    return p;
  endfunction

  function automatic logic [95:0] pack_memwb(input logic [31:0] wb_val,
                                             input logic [31:0] mem_val,
                                             input logic [31:0] waddr);
    memwb_data_t p;
    p.wb_val  = wb_val;
    p.mem_val = mem_val;
    p.waddr   = waddr;
    return p;
  endfunction

  function automatic logic [2:0] pack_ctrl(input logic rf_we, input logic mem_we,
                                           input logic mem2rf);
    stage_ctrl_t c;
    c.rf_we  = rf_we;
    c.mem_we = mem_we;
    c.mem2rf = mem2rf;
    return c;
  endfunction

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    case (s)
      MAIN:    return 2'd1;
      BOTH:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One stage entry: payload + side-effect ctrl with load enable; ctrl clear
// wins over load so a flushed entry can never carry a live write enable.
module pipe_entry #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_o <= '0;
      data_o <= '0;
    end else begin
      if (clr_i)     ctrl_o <= '0;
      else if (ld_i) ctrl_o <= ctrl_i;
      if (ld_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with synchronous flush and optional
// skid entry; ctrl bits are gated by valid so bubbles never have side effects.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OCC_W-1:0]  occ_o
);

  pipe_state_t       state_q, state_d;
  logic              acc, rel, main_ld, skid_ld;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] skid_data, main_data_d;

  assign out_valid_o = (state_q != EMPTY);
  assign rel         = out_valid_o & out_ready_i;
  assign acc         = in_valid_i & in_ready_o & ~flush_i;

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    case (state_q)
      EMPTY: if (acc) begin
        main_ld = 1'b1;
        state_d = MAIN;
      end
      MAIN: begin
        if (acc && rel) begin
          main_ld = 1'b1;
        end else if (rel) begin
          state_d = EMPTY;
        end else if (acc && SKID != 0) begin
          skid_ld = 1'b1;
          state_d = BOTH;
        end
      end
      BOTH: if (rel) begin
        main_ld = 1'b1;
        state_d = MAIN;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  // Main refills from skid when draining BOTH, otherwise from upstream.
  assign main_ctrl_d = (state_q == BOTH) ? skid_ctrl : in_ctrl_i;
  assign main_data_d = (state_q == BOTH) ? skid_data : in_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_i   (main_ld),
    .clr_i  (flush_i),
    .ctrl_i (main_ctrl_d),
    .data_i (main_data_d),
    .ctrl_o (main_ctrl),
    .data_o (out_data_o)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_i   (skid_ld),
        .clr_i  (flush_i),
        .ctrl_i (in_ctrl_i),
        .data_i (in_data_i),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data)
      );

      // Ready comes straight off a flop: no out_ready_i -> in_ready_o path.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= (state_d != BOTH);
      end
      assign in_ready_o = rdy_q;
    end else begin : g_noskid
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready_o = ~out_valid_o | out_ready_i;
    end
  endgenerate

  assign out_ctrl_o = main_ctrl & {CTRL_W{out_valid_o}};
  assign occ_o      = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: SKID=0 and SKID=1 stages share one stimulus stream; each has
// a queue-of-beats reference model checked by a negedge monitor.
module tb_pipe_stage_reg;

  typedef struct {
    logic [95:0] d;
    logic [2:0]  c;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_ctrl = '0;
  logic [95:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic [1:0]        ir, ov;
  logic [1:0][2:0]   oc;
  logic [1:0][95:0]  od;
  logic [1:0][1:0]   occ;

  beat_t sb[2][$];
  logic  exp_rdy[2];
  logic  pend_acc[2];
  logic  pend_fl = 1'b0;
  beat_t pend_beat;
  logic  chk_en = 1'b0;
  int    checks = 0;
  int    passes = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(3), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(ir[0]), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .out_ctrl_o(oc[0]),
    .out_data_o(od[0]), .occ_o(occ[0]));

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(3), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(ir[1]), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(ov[1]), .out_ready_i(out_ready), .out_ctrl_o(oc[1]),
    .out_data_o(od[1]), .occ_o(occ[1]));

  task automatic check(input string name, input int k, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut_skid%0d got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
  endtask

  // Monitor: compare every visible output against the model, pop on release.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("out_valid", k, 128'(ov[k]), 128'(sb[k].size() != 0));
        check("in_ready", k, 128'(ir[k]), 128'(exp_rdy[k]));
        check("occ", k, 128'(occ[k]), 128'(sb[k].size()));
        if (sb[k].size() != 0) begin
          check("out_data", k, 128'(od[k]), 128'(sb[k][0].d));
          check("out_ctrl", k, 128'(oc[k]), 128'(sb[k][0].c));
          if (out_ready) void'(sb[k].pop_front());
        end else begin
          check("bubble_ctrl", k, 128'(oc[k]), 128'(0));
        end
      end
    end
  end

  // Fold last cycle's accepted/flushed beat into the model after the edge.
  task automatic apply_prev();
    for (int k = 0; k < 2; k++) begin
      if (pend_fl) sb[k].delete();
      else if (pend_acc[k]) sb[k].push_back(pend_beat);
      pend_acc[k] = 1'b0;
    end
    pend_fl = 1'b0;
  endtask

  task automatic step(input logic v, input logic [95:0] d, input logic [2:0] c,
                      input logic ordy, input logic fl);
    @(posedge clk); #1;
    apply_prev();
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    for (int k = 0; k < 2; k++) begin
      // SKID=1: room unless two beats held; SKID=0: empty or draining this cycle.
      exp_rdy[k]  = (k == 1) ? (sb[k].size() < 2) : (sb[k].size() == 0 || ordy);
      pend_acc[k] = v && exp_rdy[k] && !fl;
    end
    pend_beat.d = d;
    pend_beat.c = c;
    pend_fl     = fl;
    chk_en      = 1'b1;
  endtask

  task automatic check_reset_vals();
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", k, 128'(ov[k]), 128'(0));
      check("rst_ctrl", k, 128'(oc[k]), 128'(0));
      check("rst_data", k, 128'(od[k]), 128'(0));
      check("rst_ready", k, 128'(ir[k]), 128'(1));
      check("rst_occ", k, 128'(occ[k]), 128'(0));
    end
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      exp_rdy[k]  = 1'b1;
      pend_acc[k] = 1'b0;
    end
    pend_beat.d = '0;
    pend_beat.c = '0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) step(1'b1, 96'(i), 3'(i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: downstream stalls 3 cycles while upstream keeps offering.
    for (int i = 0; i < 3; i++) step(1'b1, 96'(16 + i), 3'b101, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 96'(32 + i), 3'b011, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while full with a live ctrl=111 beat offered.
    step(1'b1, 96'h100, 3'b001, 1'b0, 1'b0);
    step(1'b1, 96'h101, 3'b010, 1'b0, 1'b0);
    step(1'b1, 96'hDEAD, 3'b111, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 96'h200, 3'b110, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall hold: one beat held, input data toggles underneath.
    step(1'b1, 96'h300, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, rnd96(), 3'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush + accept + release in the same cycle.
    step(1'b1, 96'h400, 3'b100, 1'b0, 1'b0);
    step(1'b1, 96'h401, 3'b100, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, rnd96(), 3'($urandom), ($urandom % 3) != 0,
           ($urandom % 20) == 0);

    // Reset asserted mid-stream, checked before any clock edge.
    step(1'b1, 96'h500, 3'b111, 1'b0, 1'b0);
    step(1'b1, 96'h501, 3'b111, 1'b0, 1'b0);
    @(posedge clk); #1;
    apply_prev();
    chk_en   = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #2;
    check_reset_vals();
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      exp_rdy[k] = 1'b1;
    end
    @(negedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) step(1'b1, rnd96(), 3'($urandom), ($urandom % 2) == 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid entry. It is the next-generation replacement for the fixed-field stage latches between pipeline stages (EX/MEM, MEM/WB and others). Each instance carries a payload that is held on stall and dropped on flush. It also carries side-effect control bits, such as RF write-enable and memory write-enable, which are forced to zero whenever the stage holds a bubble.

## Interface
- DATA_W, 96: payload width (for example wdata, waddr, ALU result); not cleared on flush.
- CTRL_W, 3: side-effect control width (for example rf_we, mem_we, mem2rf); gated by valid.
- SKID, 1: 0 = single entry, combinational in_ready_o; 1 = two entries (main + skid), registered in_ready_o.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous kill of all held beats and the current input beat.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat.
- in_ctrl_i  in  CTRL_W  upstream control bits.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  downstream beat valid.
- out_ready_i  in  1  downstream accepts.
- out_ctrl_o  out  CTRL_W  control bits, equal to main ctrl AND out_valid_o.
- out_data_o  out  DATA_W  payload of the main entry.
- occ_o  out  2  occupancy, 0..2 (at most 1 when SKID=0).

## Operation
- Accept = in_valid_i & in_ready_o & !flush_i. Release = out_valid_o & out_ready_i.
- States: EMPTY, MAIN (main entry valid), BOTH (main + skid valid; reachable only when SKID=1).
- EMPTY: on accept, load main and go to MAIN.
- MAIN, release only: go to EMPTY.
- MAIN, accept + release: reload main, stay in MAIN.
- MAIN, accept without release:
  - SKID=1: load skid, go to BOTH.
  - SKID=0: cannot occur, because in_ready_o = 0 in this case.
- MAIN, neither: hold all fields.
- BOTH, release: move skid to main, go to MAIN. No accept is possible because in_ready_o = 0.
- BOTH, no release: hold.
- in_ready_o:
  - SKID=0: !out_valid_o | out_ready_i.
  - SKID=1: state != BOTH, a flop output only.
- Flush: next state is EMPTY regardless of the handshake, and the input beat in the flush cycle is dropped. Payload registers keep their stale values (don't care). Ctrl registers clear to 0.
- out_ctrl_o is 0 whenever out_valid_o = 0, so a bubble can never write the RF or memory.
- Payload in the main/skid entries is held bit-exact while stalled. Beats leave in the order they were accepted, with no duplication or loss except under flush.

## Timing
- Reset values: out_valid_o=0, out_ctrl_o=0, out_data_o=0, in_ready_o=1, occ_o=0, state EMPTY. Skid registers reset to 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency is 1 cycle from accept to out_valid_o. Throughput is 1 beat per cycle when out_ready_i is held at 1.
- With SKID=1 the stage absorbs exactly one extra beat after downstream stalls, and in_ready_o falls in the following cycle.
- Simultaneous flush + accept + release: the released beat is consumed downstream, the accepted beat is dropped, and the stage ends EMPTY.
- No combinational path from out_ready_i to in_ready_o when SKID=1.

## Structure
- Shared package pipe_pkg holds the state enum pipe_state_t {EMPTY, MAIN, BOTH} and the occupancy width constant. Field-packing helpers for each stage instance also live there.
- One natural sub-module: pipe_entry, a DATA_W+CTRL_W register with load enable and ctrl clear. It is instantiated once for main and, when SKID=1, once for skid.
- State machine and handshake logic stay in the top module.

## Test plan
- Reset, SKID=1: drive rst_n=0 mid-stream -> out_valid_o=0, out_ctrl_o=0, in_ready_o=1, occ_o=0 immediately.
- Streaming, SKID=1: beats D=1..8 with out_ready_i=1 -> out_data_o shows 1..8 on consecutive cycles, 1-cycle latency.
- Backpressure, SKID=1: out_ready_i=0 for 3 cycles while in_valid_i stays high.
  - Stage accepts 2 beats, then in_ready_o=0 and occ_o=2.
  - After out_ready_i returns to 1, the beats come out in order with none lost.
- Flush, SKID=1: flush_i=1 with occ_o=2, an input beat offered, and ctrl=3'b111 -> next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0, and the offered beat never appears.
- Stall hold, SKID=1: out_valid_o=1, out_ready_i=0, and in_data_i toggled for 5 cycles -> out_data_o and out_ctrl_o are unchanged.
- SKID=0 variant, same stream as the backpressure case: in_ready_o follows out_ready_i in the same cycle while full, and occ_o never exceeds 1.
